// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Contains the arbiter state encoding and the round-robin pointer advance.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

  // Pointer that follows requester g: one past it, wrapping back to 0.
  function automatic logic [31:0] next_ptr(input logic [31:0] g,
                                           input logic [31:0] num_req);
    if (g == (num_req - 32'd1)) begin
      next_ptr = 32'd0;
    end else begin
      next_ptr = g + 32'd1;
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches req_i starting at ptr_i, then ptr_i+1, ... modulo NUM_REQ, and
// reports the first set bit as a one-hot grant and as an index.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  logic [ID_W-1:0] cand_s;

  // Walk the requesters from the pointer position and keep the first hit.
  always_comb begin
    gnt_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    cand_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = ID_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!any_o && req_i[cand_s]) begin
        any_o         = 1'b1;
        gnt_o[cand_s] = 1'b1;
        idx_o         = cand_s;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// An accepted byte is registered and held on tx_data/tx_valid until the
// transmitter takes it; the arbiter then re-arbitrates (peak 1 byte / 2 cycles).
// Optional build macro UART_ARB_LOCK_EN: keep the grant for a whole packet
// (until a byte with req_last=1 is sent) using the HOLD state.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  arb_state_t            state_q;
  logic [ID_W-1:0]       ptr_q;
  logic [ID_W-1:0]       ptr_d;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_valid_q;
  logic [ID_W-1:0]       grant_q;

  logic [NUM_REQ-1:0]    pick_gnt_s;
  logic [ID_W-1:0]       pick_idx_s;
  logic                  pick_any_s;

  logic [NUM_REQ-1:0]    grant_mask_s;
  logic [ID_W-1:0]       acc_idx_s;
  logic                  acc_s;
  logic [DATA_WIDTH-1:0] acc_data_s;

`ifdef UART_ARB_LOCK_EN
  logic                  last_q;
  logic                  acc_last_s;
`else
  logic                  unused_last_s;
  assign unused_last_s = ^req_last;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt_s),
    .idx_o (pick_idx_s),
    .any_o (pick_any_s)
  );

  // The requester just served gets lowest priority in the next arbitration.
  assign ptr_d = ID_W'(next_ptr(32'(grant_q), 32'(NUM_REQ)));

  // Decide which requester may hand over a byte this cycle.
  always_comb begin
    grant_mask_s = '0;
    acc_idx_s    = '0;
    acc_s        = 1'b0;
    if (state_q == IDLE) begin
      grant_mask_s = pick_gnt_s;
      acc_idx_s    = pick_idx_s;
      acc_s        = pick_any_s;
    end
`ifdef UART_ARB_LOCK_EN
    else if (state_q == HOLD) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_mask_s[i] = (ID_W'(i) == grant_q);
      end
      acc_idx_s = grant_q;
      acc_s     = req_valid[grant_q];
    end
`endif
    else begin
      grant_mask_s = '0;
      acc_idx_s    = '0;
      acc_s        = 1'b0;
    end
  end

  // Select the byte (and last flag) of the requester allowed to hand over.
  always_comb begin
    acc_data_s = '0;
`ifdef UART_ARB_LOCK_EN
    acc_last_s = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_mask_s[i]) begin
        acc_data_s = acc_data_s | req_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef UART_ARB_LOCK_EN
        acc_last_s = acc_last_s | req_last[i];
`endif
      end else begin
        acc_data_s = acc_data_s;
      end
    end
  end

  // Ready is combinational from the current state; reset masks it so no
  // handshake can complete while the arbiter is being cleared.
  always_comb begin
    if (rst) begin
      req_ready = '0;
    end else begin
      req_ready = grant_mask_s;
    end
  end

  // Arbiter FSM with the registered byte, grant, pointer and packet state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      grant_q    <= '0;
`ifdef UART_ARB_LOCK_EN
      last_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (acc_s) begin
            tx_data_q  <= acc_data_s;
            tx_valid_q <= 1'b1;
            grant_q    <= acc_idx_s;
`ifdef UART_ARB_LOCK_EN
            last_q     <= acc_last_s;
`endif
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            if (!last_q) begin
              state_q <= HOLD;
            end else begin
              ptr_q   <= ptr_d;
              state_q <= IDLE;
            end
`else
            ptr_q   <= ptr_d;
            state_q <= IDLE;
`endif
          end
        end
`ifdef UART_ARB_LOCK_EN
        HOLD: begin
          if (acc_s) begin
            tx_data_q  <= acc_data_s;
            tx_valid_q <= 1'b1;
            last_q     <= acc_last_s;
            state_q    <= SEND;
          end
        end
`endif
        default: begin
          tx_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (4-requester and 3-requester copies).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;

  logic [2:0]  b_req_valid;
  logic [23:0] b_req_data;
  logic [2:0]  b_req_last;
  logic [2:0]  b_req_ready;
  logic [7:0]  b_tx_data;
  logic        b_tx_valid;
  logic        b_tx_ready;
  logic [1:0]  b_grant_id;
  logic        b_busy;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy)
  );

  uart_tx_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8)) dut3 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_data(b_req_data),
    .req_last(b_req_last), .req_ready(b_req_ready), .tx_data(b_tx_data),
    .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .grant_id(b_grant_id), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'hF;
    b_req_valid = 3'b111;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    checks++; if (b_req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready3: got %b want 000", b_req_ready); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 4'h0;
    b_req_valid = 3'b000;
  endtask

  task automatic test_single();
    reset_dut();
    req_valid = 4'b0001;
    req_data = 32'h0000_00A5;
    tx_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid: got %b want 0", tx_valid); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_drop: got %b want 0000", req_ready); end
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx: got v=%b d=%h want v=1 d=a5", tx_valid, tx_data); end
    checks++; if (grant_id !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL single_grant_busy: got g=%0d b=%b want g=0 b=1", grant_id, busy); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL single_done: got b=%b v=%b want 0 0", busy, tx_valid); end
    checks++; if (tx_data !== 8'hA5 || grant_id !== 2'd0) begin errors++; $display("FAIL single_hold: got d=%h g=%0d want a5 0", tx_data, grant_id); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_tx_ready: got v=%b b=%b want 0 0", tx_valid, busy); end
  endtask

  task automatic test_round_robin();
    int n;
    int cyc;
    logic [7:0] exp_d;
    logic [1:0] exp_g;
    reset_dut();
    req_valid = 4'hF;
    req_data = 32'h1312_1110;
    tx_ready = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 6 && cyc < 40) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        exp_d = 8'h10 + 8'(n % 4);
        exp_g = 2'(n % 4);
        checks++; if (tx_data !== exp_d) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", n, tx_data, exp_d); end
        checks++; if (grant_id !== exp_g) begin errors++; $display("FAIL rr_grant[%0d]: got %0d want %0d", n, grant_id, exp_g); end
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (n != 6) begin errors++; $display("FAIL rr_count: got %0d bytes want 6", n); end
    req_valid = 4'h0;
  endtask

  task automatic test_stall();
    int bad;
    reset_dut();
    req_valid = 4'hF;
    req_data = 32'h3332_3130;
    tx_ready = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_first_ready: got %b want 0001", req_ready); end
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'h30 || req_ready !== 4'b0000 || grant_id !== 2'd0) begin
        bad++;
        $display("FAIL stall_cycle[%0d]: got v=%b d=%h r=%b g=%0d want 1 30 0000 0", i, tx_valid, tx_data, req_ready, grant_id);
      end
      @(posedge clk); #1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_summary: got %0d bad cycles want 0", bad); end
    tx_ready = 1'b1;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL stall_release: got v=%b want 1", tx_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010 || tx_valid !== 1'b0) begin errors++; $display("FAIL stall_next: got r=%b v=%b want 0010 0", req_ready, tx_valid); end
    req_valid = 4'h0;
  endtask

  task automatic test_packet();
    int n;
    int cyc;
    int idx1;
    int nexp;
    logic [7:0] exp_q [5];
`ifdef UART_ARB_LOCK_EN
    nexp = 4;
    exp_q[0] = 8'h01; exp_q[1] = 8'h02; exp_q[2] = 8'h03; exp_q[3] = 8'hFF; exp_q[4] = 8'h00;
`else
    nexp = 5;
    exp_q[0] = 8'h01; exp_q[1] = 8'hFF; exp_q[2] = 8'h02; exp_q[3] = 8'hFF; exp_q[4] = 8'h03;
`endif
    reset_dut();
    tx_ready = 1'b1;
    n = 0;
    cyc = 0;
    idx1 = 0;
    while (n < nexp && cyc < 60) begin
      req_valid[1] = (idx1 < 3);
      req_data[15:8] = 8'(idx1 + 1);
      req_last[1] = (idx1 == 2);
      req_valid[0] = (cyc >= 1);
      req_data[7:0] = 8'hFF;
      req_last[0] = 1'b1;
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        checks++; if (tx_data !== exp_q[n]) begin errors++; $display("FAIL packet_byte[%0d]: got %h want %h", n, tx_data, exp_q[n]); end
        n++;
      end
      if (req_valid[1] && req_ready[1]) idx1++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (n != nexp) begin errors++; $display("FAIL packet_count: got %0d bytes want %0d", n, nexp); end
    req_valid = 4'h0;
    req_last = 4'h0;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    req_valid = 4'b0100;
    req_data = 32'h0052_0000;
    tx_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mid_first_ready: got %b want 0100", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h52) begin errors++; $display("FAIL mid_first_tx: got v=%b d=%h want 1 52", tx_valid, tx_data); end
    @(posedge clk); #1;
    req_valid = 4'b0010;
    req_data[15:8] = 8'h61;
    tx_ready = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_ptr3_ready: got %b want 0010", req_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 4'hF;
    req_data = 32'h7372_7170;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready: got %b want 0000", req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_after_rst: got v=%b b=%b want 0 0", tx_valid, busy); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr_zero: got %b want 0001", req_ready); end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 4'h0;
    @(negedge clk);
    checks++; if (tx_data !== 8'h70 || grant_id !== 2'd0) begin errors++; $display("FAIL mid_new_tx: got d=%h g=%0d want 70 0", tx_data, grant_id); end
  endtask

  task automatic test_wrap3();
    reset_dut();
    b_req_valid = 3'b100;
    b_req_data = 24'h22_0000;
    b_tx_ready = 1'b1;
    @(negedge clk);
    checks++; if (b_req_ready !== 3'b100) begin errors++; $display("FAIL wrap_first_ready: got %b want 100", b_req_ready); end
    @(posedge clk); #1;
    b_req_valid = 3'b000;
    @(negedge clk);
    checks++; if (b_tx_valid !== 1'b1 || b_tx_data !== 8'h22 || b_grant_id !== 2'd2) begin errors++; $display("FAIL wrap_first_tx: got v=%b d=%h g=%0d want 1 22 2", b_tx_valid, b_tx_data, b_grant_id); end
    @(posedge clk); #1;
    b_req_valid = 3'b101;
    b_req_data = 24'h22_0011;
    @(negedge clk);
    checks++; if (b_req_ready !== 3'b001) begin errors++; $display("FAIL wrap_req0_first: got %b want 001", b_req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (b_tx_data !== 8'h11 || b_grant_id !== 2'd0) begin errors++; $display("FAIL wrap_req0_tx: got d=%h g=%0d want 11 0", b_tx_data, b_grant_id); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (b_req_ready !== 3'b100) begin errors++; $display("FAIL wrap_req2_next: got %b want 100", b_req_ready); end
    b_req_valid = 3'b000;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 4'h0;
    req_data = 32'h0;
    req_last = 4'h0;
    tx_ready = 1'b0;
    b_req_valid = 3'b000;
    b_req_data = 24'h0;
    b_req_last = 3'b000;
    b_tx_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_packet();
    test_reset_mid();
    test_wrap3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
